tt_response_checker: RTL and testbench
======================================

Name: tt_response_checker

Overview:
- Clocked stimulus-and-check engine for small combinational blocks, e.g. the 4-input gate-level and UDP implementations.
- Sweeps all 2^N_IN input vectors in ascending order and drives them onto two implementations of the same function.
- After a settle window, samples both responses and compares them with each other and, optionally, with a golden truth table.
- Reports pass/fail, the mismatch count and the first failing vector. It is the checking end that the directed benches feed manually today.

Parameters:
- N_IN, 4, number of DUT inputs; the sweep covers 2^N_IN vectors.
- SETTLE, 2, wait cycles between applying a vector and sampling the responses; minimum 0.
- CHECK_EXP, 0, 1 = also compare dut_a against EXPECT.
- EXPECT, 16'h0000, golden truth table of width 2^N_IN; bit v is the expected output for vector v.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a sweep; sampled only in IDLE or DONE.
- dut_a  in  1  response of implementation A, e.g. the gate-level model.
- dut_b  in  1  response of implementation B, e.g. the UDP model.
- vec_out  out  N_IN  input vector driven to both DUTs.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  result of the last completed sweep; held until the next start.
- mismatch_cnt  out  N_IN+1  number of failing vectors in the current or last sweep.
- first_fail_vec  out  N_IN  first failing vector.
- first_fail_vld  out  1  first_fail_vec is meaningful.

Behaviour:
- Reset (async, any state): state=IDLE, vec_out=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_vec=0, first_fail_vld=0, settle counter=0.
- Reset mid-sweep aborts the sweep with no done pulse. The next start runs from vector 0.
- States:
  - IDLE: waits for start.
  - RUN: applies the current vector and counts the settle window.
  - CHECK: samples and compares; one cycle.
  - DONE: holds results.
- IDLE/DONE with start=1 at edge k:
  - Go to RUN; busy=1, vec_out=0.
  - Clear mismatch_cnt, first_fail_vld, first_fail_vec and pass.
- RUN: stays SETTLE cycles, then goes to CHECK. Each vector therefore occupies SETTLE+1 cycles.
- CHECK for vector v:
  - mismatch = (dut_a != dut_b) OR (CHECK_EXP and dut_a != EXPECT[v]).
  - On mismatch: mismatch_cnt+1. If first_fail_vld=0, set first_fail_vec=v and first_fail_vld=1.
  - If v < 2^N_IN-1: vec_out=v+1 and return to RUN.
  - Otherwise go to DONE: busy=0, done=1 for exactly one cycle, pass=(final count==0).
  - The last vector's mismatch is included in pass.
- Timing: vector v is applied at edge k+v*(SETTLE+1). The done pulse is asserted at edge k+2^N_IN*(SETTLE+1). For N_IN=4 and SETTLE=2 that is k+48.
- vec_out holds its final value (all ones) in DONE. It returns to 0 on the next start.
- start while busy=1 is ignored.
- start in the same cycle as the done pulse is honoured from DONE on the next edge.
- mismatch_cnt cannot overflow: its maximum is 2^N_IN, which fits in N_IN+1 bits.
- Responses are sampled only in CHECK; dut_a/dut_b are don't-care in every other state.

Decomposition:
- Package tt_chk_pkg holds:
  - the state enum (IDLE, RUN, CHECK, DONE);
  - the localparam NVEC = 2^N_IN;
  - the settle-counter width function clog2(SETTLE+1).
- One natural sub-module: tt_settle_timer, a loadable down-counter that raises expire after SETTLE cycles. It is reused by the future multi-output checker.

Test Plan:
1. dut_a and dut_b both driven as AND of vec_out; N_IN=4, SETTLE=2; start pulse at edge 0 -> vec_out steps 0..15 every 3 cycles; done pulse at edge 48; pass=1; mismatch_cnt=0; first_fail_vld=0.
2. dut_b = dut_a inverted only when vec_out==5 -> mismatch_cnt=1, first_fail_vec=5, first_fail_vld=1, pass=0.
3. CHECK_EXP=1, EXPECT=16'h8000, dut_a=dut_b=AND of vec_out -> pass=1. Repeat with EXPECT=16'h8001 -> mismatch_cnt=1, first_fail_vec=0.
4. dut_b = ~dut_a for all vectors -> mismatch_cnt=16 (5'b10000), first_fail_vec=0, pass=0.
5. rst asserted asynchronously while vec_out==7 -> all outputs are 0 immediately with no done pulse; a new start sweeps from 0 and completes 48 cycles later.
6. start re-pulsed while busy at vector 3 -> ignored, and the sweep completes at edge 48 unchanged. start in the same cycle as the done pulse -> a new sweep begins; vec_out=0 and the counters are cleared on the next edge.

Source files
------------

// File: rtl/tt_chk_pkg.sv
// tt_chk_pkg: shared state encoding and sizing helpers for the truth-table response checker
package tt_chk_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_DONE  = 2'd3;
  localparam int N_IN_DEF = 4;
  function automatic int nvec(int n_in);
    return 1 << n_in;
  endfunction
  localparam int NVEC = nvec(N_IN_DEF);
  function automatic int cnt_w(int settle);
    return settle < 1 ? 1 : $clog2(settle + 1);
  endfunction
endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: loadable down-counter (clk, rst, load, en -> expire) that expires SETTLE cycles after load
module tt_settle_timer
  import tt_chk_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = cnt_w(SETTLE);
  localparam logic [W-1:0] INIT = W'(SETTLE > 0 ? SETTLE - 1 : 0);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= INIT;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  end
  assign expire = cnt == '0;
endmodule

// File: rtl/tt_response_checker.sv
// tt_response_checker: sweeps vec_out over all inputs, compares dut_a/dut_b (and EXPECT), reports busy/done/pass/mismatch_cnt/first_fail
module tt_response_checker
  import tt_chk_pkg::*;
#(
  parameter int                  N_IN      = 4,
  parameter int                  SETTLE    = 2,
  parameter bit                  CHECK_EXP = 1'b0,
  parameter logic [2**N_IN-1:0]  EXPECT    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_a,
  input  logic            dut_b,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_vld
);
  localparam logic [N_IN-1:0] LAST = '1;
  // With no settle window a vector goes straight to CHECK so each still takes SETTLE+1 cycles.
  localparam state_t ST_ENTRY = SETTLE > 0 ? ST_RUN : ST_CHECK;
  state_t state;
  logic go, last, mis, expire;
  logic [N_IN:0] cnt_nx;
  assign go     = start && (state == ST_IDLE || state == ST_DONE);
  assign last   = vec_out == LAST;
  assign mis    = (dut_a != dut_b) || (CHECK_EXP && dut_a != EXPECT[vec_out]);
  assign cnt_nx = mismatch_cnt + (N_IN+1)'(mis);
  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (go || (state == ST_CHECK && !last)),
    .en     (state == ST_RUN),
    .expire (expire)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      vec_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        state          <= ST_ENTRY;
        busy           <= 1'b1;
        vec_out        <= '0;
        pass           <= 1'b0;
        mismatch_cnt   <= '0;
        first_fail_vec <= '0;
        first_fail_vld <= 1'b0;
      end else if (state == ST_RUN && expire) begin
        state <= ST_CHECK;
      end else if (state == ST_CHECK) begin
        mismatch_cnt <= cnt_nx;
        if (mis && !first_fail_vld) begin
          first_fail_vec <= vec_out;
          first_fail_vld <= 1'b1;
        end
        if (last) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= cnt_nx == '0;
        end else begin
          vec_out <= vec_out + 1'b1;
          state   <= ST_ENTRY;
        end
      end
    end
  end
endmodule

// File: tb/tb_tt_response_checker.sv
// tb_tt_response_checker: randomized sweeps of three checker instances against a sweep-level timing/result model
module tb_tt_response_checker;
  localparam int S = 2;
  localparam int NV = 16;
  localparam int T = NV * (S + 1);
  localparam logic [15:0] EXP1 = 16'h8000;
  localparam logic [15:0] EXP2 = 16'h8001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] fa = '0;
  logic [15:0] em = '0;
  logic [3:0] vo [3];
  logic [3:0] ff [3];
  logic [4:0] mc [3];
  logic da [3], db [3], bsy [3], dn [3], ps [3], fv [3];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mk = 0;
  bit mrun = 1'b0;
  logic [15:0] mset [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_resp
    assign da[g] = fa[vo[g]];
    assign db[g] = fa[vo[g]] ^ em[vo[g]];
  end
  tt_response_checker #(.N_IN(4), .SETTLE(S), .CHECK_EXP(1'b0), .EXPECT(16'h0000)) u0 (
    .clk(clk), .rst(rst), .start(start), .dut_a(da[0]), .dut_b(db[0]), .vec_out(vo[0]), .busy(bsy[0]),
    .done(dn[0]), .pass(ps[0]), .mismatch_cnt(mc[0]), .first_fail_vec(ff[0]), .first_fail_vld(fv[0]));
  tt_response_checker #(.N_IN(4), .SETTLE(S), .CHECK_EXP(1'b1), .EXPECT(EXP1)) u1 (
    .clk(clk), .rst(rst), .start(start), .dut_a(da[1]), .dut_b(db[1]), .vec_out(vo[1]), .busy(bsy[1]),
    .done(dn[1]), .pass(ps[1]), .mismatch_cnt(mc[1]), .first_fail_vec(ff[1]), .first_fail_vld(fv[1]));
  tt_response_checker #(.N_IN(4), .SETTLE(S), .CHECK_EXP(1'b1), .EXPECT(EXP2)) u2 (
    .clk(clk), .rst(rst), .start(start), .dut_a(da[2]), .dut_b(db[2]), .vec_out(vo[2]), .busy(bsy[2]),
    .done(dn[2]), .pass(ps[2]), .mismatch_cnt(mc[2]), .first_fail_vec(ff[2]), .first_fail_vld(fv[2]));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] exp_set(input int i);
    return i == 0 ? em : em | (fa ^ (i == 1 ? EXP1 : EXP2));
  endfunction
  function automatic int popc(input logic [15:0] s, input int c);
    int r = 0;
    for (int v = 0; v < c; v++) r += int'(s[v]);
    return r;
  endfunction
  function automatic int first(input logic [15:0] s, input int c);
    for (int v = 0; v < c; v++) if (s[v]) return v;
    return -1;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) mrun <= 1'b0;
    else begin
      if (start && (!mrun || cyc - mk >= T)) begin
        mrun <= 1'b1;
        mk <= cyc + 1;
        for (int i = 0; i < 3; i++) mset[i] <= exp_set(i);
      end
      cyc <= cyc + 1;
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int n, c, cnt, f;
      n = cyc - mk;
      c = !mrun ? 0 : n < T ? n / (S + 1) : NV;
      cnt = mrun ? popc(mset[i], c) : 0;
      f = mrun ? first(mset[i], c) : -1;
      chk($sformatf("u%0d.vec_out", i), int'(vo[i]), !mrun ? 0 : n < T ? c : NV - 1);
      chk($sformatf("u%0d.busy", i), int'(bsy[i]), int'(mrun && n < T));
      chk($sformatf("u%0d.done", i), int'(dn[i]), int'(mrun && n == T));
      chk($sformatf("u%0d.pass", i), int'(ps[i]), int'(mrun && n >= T && cnt == 0));
      chk($sformatf("u%0d.mismatch_cnt", i), int'(mc[i]), cnt);
      chk($sformatf("u%0d.first_fail_vec", i), int'(ff[i]), f < 0 ? 0 : f);
      chk($sformatf("u%0d.first_fail_vld", i), int'(fv[i]), int'(f >= 0));
    end
  end
  task automatic run_sweep(input logic [15:0] a, input logic [15:0] e, input int repulse, output int lat);
    fa = a;
    em = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!dn[0] && lat < 200) begin
      @(negedge clk);
      lat++;
      start = lat == repulse;
    end
    start = 1'b0;
  endtask
  initial begin
    int lat;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_sweep(16'h8000, 16'h0000, -1, lat);
    chk("t1_latency", lat, 48);
    chk("t1_pass", int'(ps[0]), 1);
    chk("t1_cnt", int'(mc[0]), 0);
    chk("t1_vld", int'(fv[0]), 0);
    chk("t3_exp8000_pass", int'(ps[1]), 1);
    chk("t3_exp8001_cnt", int'(mc[2]), 1);
    chk("t3_exp8001_first", int'(ff[2]), 0);
    run_sweep(16'h8000, 16'h0020, -1, lat);
    chk("t2_latency", lat, 48);
    chk("t2_cnt", int'(mc[0]), 1);
    chk("t2_first", int'(ff[0]), 5);
    chk("t2_vld", int'(fv[0]), 1);
    chk("t2_pass", int'(ps[0]), 0);
    run_sweep(16'h8000, 16'hffff, -1, lat);
    chk("t4_cnt", int'(mc[0]), 16);
    chk("t4_first", int'(ff[0]), 0);
    chk("t4_pass", int'(ps[0]), 0);
    run_sweep(16'($urandom), 16'h0000, 10, lat);
    chk("t6_repulse_latency", lat, 48);
    for (int r = 0; r < 6; r++) begin
      run_sweep(16'($urandom), 16'($urandom & $urandom & $urandom), -1, lat);
      chk($sformatf("rand%0d_latency", r), lat, 48);
    end
    fa = 16'($urandom);
    em = 16'h0100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < 100 && vo[0] != 4'd7; w++) @(negedge clk);
    chk("t5_reached_vec7", int'(vo[0]), 7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_vec", int'(vo[0]), 0);
    chk("t5_rst_busy", int'(bsy[0]), 0);
    chk("t5_rst_done", int'(dn[0]), 0);
    chk("t5_rst_pass", int'(ps[0]), 0);
    chk("t5_rst_cnt", int'(mc[0]), 0);
    chk("t5_rst_first", int'(ff[0]), 0);
    chk("t5_rst_vld", int'(fv[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_sweep(16'h8000, 16'h0000, -1, lat);
    chk("t5_restart_latency", lat, 48);
    chk("t5_restart_pass", int'(ps[0]), 1);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
